// File: rtl/apb_mem_completer.sv
// APB4 completer backed by a byte-strobed word memory. It adds programmable wait states and
// flags misaligned, out-of-range and illegal-strobe accesses as errored transfers.
//
// state  | meaning
// IDLE   | no transfer in flight; waiting for a SETUP cycle
// ACCESS | transfer latched; counting wait states, then completing or aborting
module apb_mem_completer #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int DEPTH         = 256,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_WIDTH-1:0]    paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [STRB_WIDTH-1:0]    pstrb,
    input  logic [3:0]               wait_cfg,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int OFF   = $clog2(STRB_WIDTH);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [IDX_W-1:0]        r_idx;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_strb;
    logic                    r_err;
    logic [3:0]              r_wait_cnt;
    logic                    r_pready;

    logic [ADDR_WIDTH-1:0]   w_word;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_bad_strb;
    logic                    w_setup;
    logic                    w_complete;
    logic                    w_abort;
    logic                    w_commit_wr;
    logic                    w_commit_err;

    // Error decode is evaluated on the SETUP-cycle bus values only.
    assign w_word         = paddr >> OFF;
    assign w_misaligned   = (paddr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
    assign w_out_of_range = w_word >= ADDR_WIDTH'(DEPTH);
    assign w_bad_strb     = !pwrite && (pstrb != '0);

    assign w_setup    = psel && !penable;
    assign w_complete = (r_state == S_ACCESS) && r_pready && psel && penable;
    assign w_abort    = (r_state == S_ACCESS) && !psel;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_setup) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_abort || w_complete) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pready       = r_pready;
        pslverr      = r_pready && r_err;
        prdata       = (r_pready && !r_write && !r_err) ? r_mem[r_idx] : '0;
        w_commit_wr  = w_complete && r_write && !r_err;
        w_commit_err = w_complete && r_err;
    end

    // pready is registered so it rises on the cycle the wait counter runs out.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_pready   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_setup) begin
                r_idx      <= w_word[IDX_W-1:0];
                r_write    <= pwrite;
                r_wdata    <= pwdata;
                r_strb     <= pstrb;
                r_err      <= w_misaligned || w_out_of_range || w_bad_strb;
                r_wait_cnt <= wait_cfg;
                r_pready   <= (wait_cfg == 4'd0);
            end
        end else if (w_abort || w_complete) begin
            r_wait_cnt <= '0;
            r_pready   <= 1'b0;
        end else if (!r_pready) begin
            r_wait_cnt <= (r_wait_cnt != 4'd0) ? r_wait_cnt - 4'd1 : 4'd0;
            r_pready   <= (r_wait_cnt <= 4'd1);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit_wr) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            err_count <= '0;
        end else if (w_commit_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Directed bench for apb_mem_completer: drives APB transfers on the falling edge and checks
// hand-computed responses with immediate assertions.
module tb_apb_mem_completer;

    logic        pclk;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [3:0]  wait_cfg;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic        err;
    int          waits;
    logic        seen;

    apb_mem_completer dut (
        .pclk      (pclk),
        .preset    (preset),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .wait_cfg  (wait_cfg),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .err_count (err_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after completion so that a
    // following call issues its SETUP back-to-back.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] wcfg,
                            output logic [31:0] rdata, output logic slverr, output int nwait);
        logic got;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; wait_cfg = wcfg;
        #1 check("setup_pready_low", pready, 1'b0);
        @(negedge pclk);
        penable = 1'b1; paddr = addr ^ 32'h4; pwdata = ~data; pstrb = ~strb; wait_cfg = 4'hF;
        nwait = 0; got = 1'b0; rdata = '0; slverr = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (pready) begin
                rdata = prdata; slverr = pslverr; got = 1'b1;
            end else begin
                check("wait_pslverr_low", pslverr, 1'b0);
                check("wait_prdata_zero", prdata, 32'h0);
                nwait++;
                @(negedge pclk);
            end
        end
        if (!got) check("ready_timeout", pready, 1'b1);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
        #1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_err_count", err_count, 8'h0);
        @(negedge pclk); @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // full write then read-back, zero wait
        apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, rd, err, waits);
        check("wr10_waits", waits, 0);
        check("wr10_pslverr", err, 1'b0);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_pslverr", err, 1'b0);

        // partial strobe: lanes 0 and 2 updated
        apb_xfer(1'b1, 32'h10, 32'h11223344, 4'h5, 4'd0, rd, err, waits);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("rd10_partial", rd, 32'hDE22BE44);

        // three wait states: 3 low ACCESS cycles, ready on 4th
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd3, rd, err, waits);
        check("wait3_waits", waits, 3);
        check("wait3_data", rd, 32'hDE22BE44);

        // back-to-back write then read of a fresh word
        apb_xfer(1'b1, 32'h40, 32'hA5A55A5A, 4'hF, 4'd1, rd, err, waits);
        apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("raw40_data", rd, 32'hA5A55A5A);

        // error transfers
        apb_xfer(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 4'd0, rd, err, waits);
        check("misalign_pslverr", err, 1'b1);
        check("misalign_prdata", rd, 32'h0);
        apb_xfer(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 4'd2, rd, err, waits);
        check("oor_pslverr", err, 1'b1);
        check("oor_waits", waits, 2);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h1, 4'd0, rd, err, waits);
        check("badstrb_pslverr", err, 1'b1);
        check("badstrb_prdata", rd, 32'h0);
        check("err_count_3", err_count, 8'd3);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("no_write_on_err", rd, 32'hDE22BE44);
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("word0_untouched", rd, 32'h0);

        // abort: psel dropped in the second ACCESS cycle of a wait_cfg=4 write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; wait_cfg = 4'd4;
        @(negedge pclk);
        penable = 1'b1;
        #1 check("abort_acc1_pready", pready, 1'b0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 if (pready) seen = 1'b1;
            @(negedge pclk);
        end
        check("abort_no_pready", seen, 1'b0);
        apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("abort_mem20", rd, 32'h0);
        check("abort_idle_waits", waits, 0);
        check("abort_err_count", err_count, 8'd3);

        // asynchronous reset during the wait of a write to 0x30
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30;
        pwdata = 32'h12345678; pstrb = 4'hF; wait_cfg = 4'd5;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        #2 preset = 1'b1;
        #1;
        check("midrst_pready", pready, 1'b0);
        check("midrst_pslverr", pslverr, 1'b0);
        check("midrst_prdata", prdata, 32'h0);
        check("midrst_err_count", err_count, 8'h0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        apb_xfer(1'b0, 32'h30, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("midrst_mem30", rd, 32'h0);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, waits);
        check("midrst_mem10_cleared", rd, 32'h0);

        // a zero-wait read with pready high, interrupted by reset
        apb_xfer(1'b1, 32'h8, 32'h0BADF00D, 4'hF, 4'd0, rd, err, waits);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8; pstrb = 4'h0; wait_cfg = 4'd0;
        @(negedge pclk);
        penable = 1'b1;
        #1 check("rdrst_prdata_before", prdata, 32'h0BADF00D);
        #1 preset = 1'b1;
        #1;
        check("rdrst_pready", pready, 1'b0);
        check("rdrst_prdata", prdata, 32'h0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            apb_xfer(1'b0, 32'h2, 32'h0, 4'h0, 4'd0, rd, err, waits);
            if (i == 254) check("sat_count_255", err_count, 8'd255);
        end
        check("sat_count_held", err_count, 8'd255);
        check("sat_last_pslverr", err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
